// File: rtl/fifo_flags_if.sv
// Producer/consumer bundle for fifo_flags: write/read handshake, read data and status.
// The FIFO side takes the slave modport; the driving block takes master.
interface fifo_flags_if #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             wr;
  logic [WIDTH-1:0] wr_data;
  logic             rd;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;
  logic             clr_err;

  modport master (
    output wr, wr_data, rd, clr_err,
    input  rd_data, rd_valid, empty, full, almost_empty, almost_full,
           count, overflow, underflow
  );

  modport slave (
    input  wr, wr_data, rd, clr_err,
    output rd_data, rd_valid, empty, full, almost_empty, almost_full,
           count, overflow, underflow
  );
endinterface

// File: rtl/fifo_flags.sv
// Single-clock FIFO with occupancy, almost flags and sticky errors; FWFT (0-cycle) or registered read (1 cycle).
// Writes to a full FIFO are dropped unless a read pops in the same cycle; reads of an empty FIFO are dropped.
module fifo_flags #(
  parameter int DEPTH      = 8,
  parameter int WIDTH      = 32,
  parameter int AFULL_LVL  = DEPTH - 2,
  parameter int AEMPTY_LVL = 2,
  parameter int FWFT       = 1
) (
  input  logic         clk,
  input  logic         rst,
  fifo_flags_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LVL);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LVL);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0] wrptr_q, wrptr_d;
  logic [CW-1:0] rdptr_q, rdptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic          empty;
  logic          full;
  logic          rd_acc;
  logic          wr_acc;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  assign empty  = (count_q == '0);
  assign full   = (count_q == DEPTH_C);
  assign wr_idx = wrptr_q[AW-1:0];
  assign rd_idx = rdptr_q[AW-1:0];

  // A pop in the same cycle frees a slot, so a full FIFO still accepts the write.
  assign rd_acc = bus.rd & ~empty;
  assign wr_acc = bus.wr & (~full | rd_acc);

  always_comb begin
    wrptr_d     = wrptr_q;
    rdptr_d     = rdptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q & ~bus.clr_err;
    underflow_d = underflow_q & ~bus.clr_err;
    if (wr_acc) wrptr_d = wrptr_q + 1'b1;
    if (rd_acc) rdptr_d = rdptr_q + 1'b1;
    count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
    if (bus.wr & ~wr_acc) overflow_d = 1'b1;
    if (bus.rd & ~rd_acc) underflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrptr_q     <= '0;
      rdptr_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wrptr_q     <= wrptr_d;
      rdptr_q     <= rdptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !rst) mem[wr_idx] <= bus.wr_data;
  end

  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.almost_empty = (count_q <= AEMPTY_C);
  assign bus.almost_full  = (count_q >= AFULL_C);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.rd_data  = mem[rd_idx];
      assign bus.rd_valid = ~empty;
    end else begin : g_reg
      logic [WIDTH-1:0] rd_data_q, rd_data_d;
      logic             rd_valid_q, rd_valid_d;

      // rdptr never equals wrptr while non-empty, so this read never races a write.
      always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_acc;
        if (rd_acc) rd_data_d = mem[rd_idx];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_data_q  <= rd_data_d;
          rd_valid_q <= rd_valid_d;
        end
      end

      assign bus.rd_data  = rd_data_q;
      assign bus.rd_valid = rd_valid_q;
    end
  endgenerate
endmodule

// File: tb/tb_fifo_flags.sv
// Drives an FWFT and a registered-read fifo_flags with identical stimulus and
// checks both against one queue-based reference of the buffer contents.
module tb_fifo_flags;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_flags_if #(.DEPTH(8), .WIDTH(32)) bus_a ();
  fifo_flags_if #(.DEPTH(8), .WIDTH(32)) bus_b ();

  fifo_flags #(.DEPTH(8), .WIDTH(32), .FWFT(1)) u_fwft (.clk(clk), .rst(rst), .bus(bus_a));
  fifo_flags #(.DEPTH(8), .WIDTH(32), .FWFT(0)) u_reg  (.clk(clk), .rst(rst), .bus(bus_b));

  int total = 0;
  int bad   = 0;

  logic [31:0] q[$];
  logic        m_ov, m_uf;
  logic [31:0] b_data;
  logic        b_vld;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic w, input logic [31:0] d, input logic r, input logic c);
    bus_a.wr = w; bus_a.wr_data = d; bus_a.rd = r; bus_a.clr_err = c;
    bus_b.wr = w; bus_b.wr_data = d; bus_b.rd = r; bus_b.clr_err = c;
  endtask

  task automatic check_state();
    int n;
    n = q.size();
    check("count_a",   32'(bus_a.count),        32'(n));
    check("empty_a",   32'(bus_a.empty),        32'(n == 0));
    check("full_a",    32'(bus_a.full),         32'(n == 8));
    check("aempty_a",  32'(bus_a.almost_empty), 32'(n <= 2));
    check("afull_a",   32'(bus_a.almost_full),  32'(n >= 6));
    check("ovf_a",     32'(bus_a.overflow),     32'(m_ov));
    check("udf_a",     32'(bus_a.underflow),    32'(m_uf));
    check("rdvld_a",   32'(bus_a.rd_valid),     32'(n != 0));
    check("count_b",   32'(bus_b.count),        32'(n));
    check("ovf_b",     32'(bus_b.overflow),     32'(m_ov));
    check("udf_b",     32'(bus_b.underflow),    32'(m_uf));
    check("rdvld_b",   32'(bus_b.rd_valid),     32'(b_vld));
    check("rddata_b",  bus_b.rd_data,           b_data);
  endtask

  task automatic model_reset();
    q.delete();
    m_ov = 1'b0; m_uf = 1'b0; b_data = '0; b_vld = 1'b0;
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input logic w, input logic [31:0] d, input logic r, input logic c);
    logic        rd_acc, wr_acc;
    logic [31:0] exp;
    check_state();
    drive(w, d, r, c);
    rd_acc = r && (q.size() != 0);
    wr_acc = w && ((q.size() != 8) || rd_acc);
    exp = '0;
    if (rd_acc) begin
      exp = q.pop_front();
      check("fwft_data", bus_a.rd_data, exp);
    end
    @(posedge clk);
    if (wr_acc) q.push_back(d);
    m_ov  = (m_ov & ~c) | (w & ~wr_acc);
    m_uf  = (m_uf & ~c) | (r & ~rd_acc);
    b_vld = rd_acc;
    if (rd_acc) b_data = exp;
    @(negedge clk);
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input logic w, input logic r);
    drive(w, 32'hBAD0_0BAD, r, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    do_reset(1'b0, 1'b0);
    check_state();

    // Fill 1..8, overflow attempt, drain in order.
    for (int i = 1; i <= 8; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'hDEAD, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Full with simultaneous write and read: count holds, new word comes out last.
    for (int i = 0; i < 8; i++) step(1'b1, 32'h40 + 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'h77, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Empty with simultaneous write and read: read rejected, write kept.
    step(1'b1, 32'hA5, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);

    // Streaming across pointer wrap at constant occupancy 3.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
    for (int i = 3; i < 27; i++) step(1'b1, 32'h100 + 32'(i), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Registered read: single pop, then idle so rd_data must hold.
    step(1'b1, 32'h11, 1'b0, 1'b0);
    step(1'b1, 32'h22, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

    // Mid-stream reset with count 5 and overflow set; reset beats a concurrent write.
    for (int i = 0; i < 8; i++) step(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'hDEAD, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("pre_rst_count", 32'(bus_a.count), 32'd5);
    check("pre_rst_ovf",   32'(bus_a.overflow), 32'd1);
    do_reset(1'b1, 1'b1);
    check("rst_count", 32'(bus_a.count), 32'd0);
    check("rst_empty", 32'(bus_a.empty), 32'd1);
    check("rst_ovf",   32'(bus_a.overflow), 32'd0);
    check("rst_vld_b", 32'(bus_b.rd_valid), 32'd0);
    check_state();

    // clr_err together with a dropped write leaves overflow set.
    for (int i = 0; i < 8; i++) step(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'hDEAD, 1'b0, 1'b1);
    check("clr_vs_err_ovf", 32'(bus_a.overflow), 32'd1);
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);
    check_state();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_flags.md
Name: fifo_flags

Overview:
- Parametrised successor to the team's basic synchronous FIFO.
- Single-clock circular buffer adding:
  - occupancy count
  - programmable almost-full / almost-empty thresholds
  - sticky overflow / underflow error flags
  - selectable read mode: first-word-fall-through (FWFT) or registered-read with a valid strobe.
- Sits between producer/consumer blocks in the datapath and is the drop-in buffer for streams needing back-pressure headroom.

Parameters:
- DEPTH, 8, entries; power of 2, >= 2
- WIDTH, 32, data bits per entry
- AFULL_LVL, DEPTH-2, almost_full asserted when count >= AFULL_LVL; legal range 1..DEPTH
- AEMPTY_LVL, 2, almost_empty asserted when count <= AEMPTY_LVL; legal range 0..DEPTH-1
- FWFT, 1, 1 = head entry presented on rd_data while !empty; 0 = registered read, data one cycle after accepted rd

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr  in  1  write request
- wr_data  in  WIDTH  write data
- rd  in  1  read request (FWFT: pop/acknowledge of head)
- rd_data  out  WIDTH  read data
- rd_valid  out  1  FWFT=1: equals !empty; FWFT=0: one-cycle pulse, rd_data valid
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_empty  out  1  count <= AEMPTY_LVL
- almost_full  out  1  count >= AFULL_LVL
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write attempted and dropped
- underflow  out  1  sticky: read attempted with nothing to read
- clr_err  in  1  clears overflow/underflow

Behaviour:
- State: wrptr, rdptr of $clog2(DEPTH)+1 bits (MSB is the wrap bit), count register, mem[DEPTH].
- Pointer index = low $clog2(DEPTH) bits; increments wrap naturally modulo 2*DEPTH.
- Reset (rst=1 at posedge):
  - pointers, count = 0; empty=1, almost_empty=1, full=0, almost_full=0 (unless AFULL_LVL=0, illegal)
  - rd_valid=0, overflow=0, underflow=0; rd_data=0 when FWFT=0
  - mem contents not reset.
  - rst wins over every other input in the same cycle, including mid-stream.
- Write acceptance: wr_acc = wr & (!full | rd_acc). Accepted data stored at wrptr; wrptr+1 next cycle.
- Read acceptance: rd_acc = rd & !empty. Accepted read advances rdptr next cycle.
- Simultaneous wr & rd:
  - When full: both accepted, count unchanged, full stays 1.
  - When empty: write accepted, read rejected (underflow set), count becomes 1.
- count_next = count + wr_acc - rd_acc. Never exceeds DEPTH or goes below 0.
- All status flags derive from registered state only; no combinational path from wr/rd to any flag.
- FWFT=1:
  - rd_data = mem[rdptr] combinationally; rd_valid = !empty.
  - A written word is visible on rd_data the cycle after the write (empty deasserts same edge).
  - rd_data is don't-care while empty.
- FWFT=0:
  - On rd_acc, rd_data <= mem[rdptr] and rd_valid <= 1 at the same edge; otherwise rd_valid <= 0 and rd_data holds.
  - Latency from accepted rd to data: 1 cycle.
  - Read of a word written in the immediately preceding cycle returns the new data (no read-during-write hazard, since rdptr != wrptr when !empty).
- overflow <= 1 when wr & !wr_acc; underflow <= 1 when rd & !rd_acc.
- clr_err=1 clears both flags. A new error in the same cycle as clr_err wins (flag ends set).
- Dropped write: memory and wrptr untouched.

Test Plan:
- Reset, then 8 writes 0x1..0x8 (DEPTH=8), no reads -> count 0..8 stepwise; almost_full at count 6; full at 8; then 8 reads return 0x1..0x8 in order, empty=1, almost_empty rises at count 2.
- Full FIFO, wr=1 rd=0 with 0xDEAD -> overflow=1, count stays 8, subsequent reads never return 0xDEAD. Then full with wr=1 rd=1 -> count stays 8, written word read out 8th later.
- Empty FIFO, wr=1 rd=1 same cycle, data 0xA5 -> count=1, underflow=1; next cycle rd returns 0xA5.
- Stream 3*DEPTH words at one write + one read per cycle after priming 3 entries -> data in order across pointer wrap; count constant 3; no error flags.
- FWFT=0: write 0x11, 0x22; rd pulsed one cycle -> rd_valid high exactly the next cycle with rd_data=0x11; rd_data holds 0x11 after valid drops.
- Mid-stream rst with count=5 and overflow=1 -> next cycle count=0, empty=1, overflow=0, rd_valid=0. clr_err asserted together with a failed write -> overflow remains 1.
